// File: rtl/demultiplexor_1in_2out_pkg.sv
// demultiplexor_1in_2out_pkg: shared widths, buffer depth and destination select encodings
package demultiplexor_1in_2out_pkg;
    localparam int   DB_DEFAULT = 16;
    localparam int   DEPTH      = 2;
    localparam logic SEL_A      = 1'b1;
    localparam logic SEL_B      = 1'b0;
endpackage

// File: rtl/demux_out_buffer.sv
// demux_out_buffer: 2-entry output FIFO with valid/ready pop; slot 0 is always the head
module demux_out_buffer
    import demultiplexor_1in_2out_pkg::*;
#(
    parameter int W = DB_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    output logic [W-1:0] dout,
    output logic         valid,
    input  logic         ready
);
    logic [W-1:0] r_s0;
    logic [W-1:0] r_s1;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign full   = r_count == 2'(DEPTH);
    assign valid  = r_count != 2'd0;
    assign dout   = r_s0;
    assign w_push = push && !full;
    assign w_pop  = ready && valid;

    // Head slot is only rewritten when new data becomes head, so Salida holds its last value when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0    <= '0;
            r_s1    <= '0;
            r_count <= '0;
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop)
                r_s0 <= (r_count == 2'd2) ? r_s1 : (w_push ? din : r_s0);
            else if (w_push && r_count == 2'd0)
                r_s0 <= din;
            if (w_push && !w_pop && r_count == 2'd1)
                r_s1 <= din;
        end
    end
endmodule

// File: rtl/demultiplexor_1in_2out.sv
// demultiplexor_1in_2out: steers one valid/ready input stream into one of two buffered outputs
module demultiplexor_1in_2out
    import demultiplexor_1in_2out_pkg::*;
#(
    parameter int DB = DB_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DB-1:0] DatoIn,
    input  logic          Sel,
    input  logic          ValidIn,
    output logic          ReadyIn,
    output logic [DB-1:0] SalidaA,
    output logic          ValidA,
    input  logic          ReadyA,
    output logic [DB-1:0] SalidaB,
    output logic          ValidB,
    input  logic          ReadyB
);
    logic w_full_a;
    logic w_full_b;
    logic w_xfer;

    // Readiness comes from registered fill state only, never from the consumers' ready
    assign ReadyIn = (Sel == SEL_A) ? !w_full_a : !w_full_b;
    assign w_xfer  = ValidIn && ReadyIn;

    demux_out_buffer #(.W(DB)) u_buf_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_xfer && Sel == SEL_A),
        .din   (DatoIn),
        .full  (w_full_a),
        .dout  (SalidaA),
        .valid (ValidA),
        .ready (ReadyA)
    );

    demux_out_buffer #(.W(DB)) u_buf_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_xfer && Sel == SEL_B),
        .din   (DatoIn),
        .full  (w_full_b),
        .dout  (SalidaB),
        .valid (ValidB),
        .ready (ReadyB)
    );
endmodule
